joybus_rx_decoder: RTL and testbench

//  Decodes the N64 Joybus one-wire bitstream after glitch filtering into bytes plus frame

---
 rtl/joybus_pkg.sv | 25 ++
 rtl/joybus_phase_timer.sv | 43 ++++
 rtl/joybus_rx_decoder.sv | 168 ++++++++++++++++
 tb/tb_joybus_rx_decoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/joybus_pkg.sv
// ============================================================================
// Module  : joybus_pkg
// Brief   : Shared Joybus types and default bit-cell timing (RX and TX).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package joybus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOW     = 2'd1,
    HIGH    = 2'd2,
    WAIT_HI = 2'd3
  } rx_state_t;

  // Cycle counts at a 50 MHz system clock.
  localparam int unsigned c_BIT_THRESH   = 100;
  localparam int unsigned c_LOW_TIMEOUT  = 400;
  localparam int unsigned c_IDLE_TIMEOUT = 250;

endpackage

`default_nettype wire

// File: rtl/joybus_phase_timer.sv
// ============================================================================
// Module  : joybus_phase_timer
// Brief   : Saturating phase-length counter with clear and ==LIMIT compare.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module joybus_phase_timer #(
  parameter int CNT_W = 10,
  parameter int LIMIT = 400
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_hit
);

  localparam logic [CNT_W-1:0] c_MAX   = '1;
  localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(LIMIT);

  logic [CNT_W-1:0] r_count;

  // Clear loads 1 so the count equals the number of samples in the phase,
  // the edge sample included.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= CNT_W'(1);
    end else if (i_en && (r_count != c_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_hit   = (r_count == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/joybus_rx_decoder.sv
// ============================================================================
// Module  : joybus_rx_decoder
// Brief   : Decodes the filtered Joybus line into bytes and frame boundaries.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module joybus_rx_decoder
  import joybus_pkg::*;
#(
  parameter int BIT_THRESH   = c_BIT_THRESH,
  parameter int LOW_TIMEOUT  = c_LOW_TIMEOUT,
  parameter int IDLE_TIMEOUT = c_IDLE_TIMEOUT,
  parameter int MAX_BYTES    = 64,
  parameter int CNT_W        = 10
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         line_in,
  output logic [7:0]                   byte_data,
  output logic                         byte_valid,
  output logic [$clog2(MAX_BYTES)-1:0] byte_index,
  output logic                         frame_done,
  output logic                         frame_err,
  output logic                         busy
);

  localparam int IW  = $clog2(MAX_BYTES);
  localparam int BCW = $clog2(MAX_BYTES + 1);

  rx_state_t        r_state, w_state_nxt;
  logic             r_line_prev, r_armed;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic [BCW-1:0]   r_byte_cnt;
  logic             r_dropped;

  logic             w_fall, w_rise, w_bit, w_frame_ok;
  logic             w_low_clr, w_high_clr, w_take_bit, w_frame_end, w_abort;
  logic             w_low_hit, w_high_hit;
  logic [CNT_W-1:0] w_low_cnt, w_high_cnt_unused;
  logic [7:0]       w_byte;

  assign w_fall     = r_line_prev & ~line_in;
  assign w_rise     = ~r_line_prev & line_in;
  assign w_bit      = (w_low_cnt < CNT_W'(BIT_THRESH));
  assign w_byte     = {r_shift[6:0], w_bit};
  assign w_frame_ok = (r_bit_cnt == 3'd1) && r_shift[0] &&
                      (r_byte_cnt != '0) && !r_dropped;

  joybus_phase_timer #(.CNT_W(CNT_W), .LIMIT(LOW_TIMEOUT)) u_low_timer (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .i_clr   (w_low_clr),
    .i_en    (r_state == LOW),
    .o_count (w_low_cnt),
    .o_hit   (w_low_hit)
  );

  joybus_phase_timer #(.CNT_W(CNT_W), .LIMIT(IDLE_TIMEOUT)) u_high_timer (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .i_clr   (w_high_clr),
    .i_en    (r_state == HIGH),
    .o_count (w_high_cnt_unused),
    .o_hit   (w_high_hit)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_low_clr   = 1'b0;
    w_high_clr  = 1'b0;
    w_take_bit  = 1'b0;
    w_frame_end = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      // A fall only counts once the line has been seen high since reset.
      IDLE: begin
        if (w_fall && r_armed) begin
          w_state_nxt = LOW;
          w_low_clr   = 1'b1;
        end
      end
      LOW: begin
        if (w_rise) begin
          w_take_bit  = 1'b1;
          w_high_clr  = 1'b1;
          w_state_nxt = HIGH;
        end else if (w_low_hit) begin
          w_abort     = 1'b1;
          w_state_nxt = WAIT_HI;
        end
      end
      HIGH: begin
        if (w_fall) begin
          w_low_clr   = 1'b1;
          w_state_nxt = LOW;
        end else if (w_high_hit) begin
          w_frame_end = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      WAIT_HI: begin
        if (line_in) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_line_prev <= 1'b1;
      r_armed     <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_dropped   <= 1'b0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      byte_index  <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      r_line_prev <= line_in;
      if (line_in) r_armed <= 1'b1;
      byte_valid  <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= (w_state_nxt != IDLE);

      if (w_take_bit) begin
        r_shift <= w_byte;
        if (r_bit_cnt == 3'd7) begin
          r_bit_cnt <= '0;
          if (r_byte_cnt < BCW'(MAX_BYTES)) begin
            byte_valid <= 1'b1;
            byte_data  <= w_byte;
            byte_index <= r_byte_cnt[IW-1:0];
            r_byte_cnt <= r_byte_cnt + 1'b1;
          end else begin
            r_dropped <= 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end

      if (w_frame_end || w_abort) begin
        frame_done <= 1'b1;
        frame_err  <= w_abort | ~w_frame_ok;
        r_shift    <= '0;
        r_bit_cnt  <= '0;
        r_byte_cnt <= '0;
        r_dropped  <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_joybus_rx_decoder.sv
// ============================================================================
// Module  : tb_joybus_rx_decoder
// Brief   : Directed, table-driven bench for joybus_rx_decoder.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_joybus_rx_decoder;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       line_in = 1'b1;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic [5:0] byte_index;
  logic       frame_done;
  logic       frame_err;
  logic       busy;

  joybus_rx_decoder dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .line_in    (line_in),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_index (byte_index),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #10 sys_clk = ~sys_clk;

  typedef struct {
    int          nbits;
    logic [31:0] bits;
    int          lo1;
    int          lo0;
    bit          stop;
    int          exp_n;
    logic [7:0]  exp_b0;
    logic [7:0]  exp_b1;
    bit          exp_err;
  } vec_t;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         n_bv = 0;
  int         n_fd = 0;
  int         last_err = 0;
  int         cyc = 0;
  int         fd_at = 0;
  logic [7:0] cap_d [16];
  int         cap_i [16];
  vec_t       tbl [7];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge sys_clk) cyc++;

  always @(negedge sys_clk) begin
    if (byte_valid) begin
      if (n_bv < 16) begin
        cap_d[n_bv] = byte_data;
        cap_i[n_bv] = int'(byte_index);
      end
      n_bv++;
      chk("valid_vs_done", int'(frame_done), 0);
    end
    if (frame_done) begin
      n_fd++;
      last_err = int'(frame_err);
      fd_at = cyc;
    end
  end

  task automatic hold(input logic v, input int n);
    line_in = v;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic clr_cap();
    n_bv = 0;
    n_fd = 0;
    last_err = 0;
  endtask

  task automatic send_frame(input vec_t v);
    int lo;
    for (int i = 0; i < v.nbits; i++) begin
      lo = v.bits[v.nbits-1-i] ? v.lo1 : v.lo0;
      hold(1'b0, lo);
      hold(1'b1, 200 - lo);
    end
    if (v.stop) begin
      hold(1'b0, 50);
      hold(1'b1, 100);
    end
    hold(1'b1, 300);
  endtask

  task automatic check_frame(input string tag, input vec_t v);
    chk({tag, "_done_cnt"}, n_fd, 1);
    chk({tag, "_err"}, last_err, int'(v.exp_err));
    chk({tag, "_byte_cnt"}, n_bv, v.exp_n);
    if (v.exp_n >= 1 && n_bv >= 1) begin
      chk({tag, "_b0"}, int'(cap_d[0]), int'(v.exp_b0));
      chk({tag, "_i0"}, cap_i[0], 0);
    end
    if (v.exp_n >= 2 && n_bv >= 2) begin
      chk({tag, "_b1"}, int'(cap_d[1]), int'(v.exp_b1));
      chk({tag, "_i1"}, cap_i[1], 1);
    end
    chk({tag, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    vec_t v6;
    int   t0;

    tbl[0] = '{nbits: 8,  bits: 32'h00,   lo1: 50, lo0: 150, stop: 1'b1,
               exp_n: 1, exp_b0: 8'h00, exp_b1: 8'h00, exp_err: 1'b0};
    tbl[1] = '{nbits: 16, bits: 32'h01A5, lo1: 50, lo0: 150, stop: 1'b1,
               exp_n: 2, exp_b0: 8'h01, exp_b1: 8'hA5, exp_err: 1'b0};
    tbl[2] = '{nbits: 8,  bits: 32'h5A,   lo1: 99, lo0: 100, stop: 1'b1,
               exp_n: 1, exp_b0: 8'h5A, exp_b1: 8'h00, exp_err: 1'b0};
    tbl[3] = '{nbits: 11, bits: 32'h00D,  lo1: 50, lo0: 150, stop: 1'b0,
               exp_n: 1, exp_b0: 8'h01, exp_b1: 8'h00, exp_err: 1'b1};
    tbl[4] = '{nbits: 8,  bits: 32'hFF,   lo1: 50, lo0: 150, stop: 1'b0,
               exp_n: 1, exp_b0: 8'hFF, exp_b1: 8'h00, exp_err: 1'b1};
    tbl[5] = '{nbits: 0,  bits: 32'h0,    lo1: 50, lo0: 150, stop: 1'b1,
               exp_n: 0, exp_b0: 8'h00, exp_b1: 8'h00, exp_err: 1'b1};
    tbl[6] = '{nbits: 9,  bits: 32'h078,  lo1: 50, lo0: 150, stop: 1'b0,
               exp_n: 1, exp_b0: 8'h3C, exp_b1: 8'h00, exp_err: 1'b1};

    // Reset state
    repeat (5) @(negedge sys_clk);
    chk("rst_byte_valid", int'(byte_valid), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_frame_err",  int'(frame_err), 0);
    chk("rst_busy",       int'(busy), 0);
    chk("rst_byte_data",  int'(byte_data), 0);
    chk("rst_byte_index", int'(byte_index), 0);
    sys_rst = 1'b0;
    hold(1'b1, 20);

    for (int k = 0; k < 7; k++) begin
      clr_cap();
      send_frame(tbl[k]);
      check_frame($sformatf("vec%0d", k), tbl[k]);
    end

    // Line stuck low
    clr_cap();
    hold(1'b1, 20);
    t0 = cyc;
    hold(1'b0, 500);
    chk("stuck_done_cnt", n_fd, 1);
    chk("stuck_err", last_err, 1);
    chk("stuck_time_ok", int'((fd_at - t0) >= 399 && (fd_at - t0) <= 403), 1);
    chk("stuck_busy_low", int'(busy), 1);
    chk("stuck_no_bytes", n_bv, 0);
    hold(1'b1, 3);
    chk("stuck_busy_released", int'(busy), 0);
    hold(1'b1, 300);
    chk("stuck_no_extra_done", n_fd, 1);

    // Reset mid-byte with the line low through reset release
    clr_cap();
    for (int i = 0; i < 3; i++) begin
      hold(1'b0, 50);
      hold(1'b1, 150);
    end
    hold(1'b0, 30);
    sys_rst = 1'b1;
    hold(1'b0, 5);
    sys_rst = 1'b0;
    hold(1'b0, 50);
    hold(1'b1, 300);
    chk("midrst_no_bytes", n_bv, 0);
    chk("midrst_no_done", n_fd, 0);
    chk("midrst_busy", int'(busy), 0);
    clr_cap();
    v6 = '{nbits: 8, bits: 32'hC3, lo1: 50, lo0: 150, stop: 1'b1,
           exp_n: 1, exp_b0: 8'hC3, exp_b1: 8'h00, exp_err: 1'b0};
    send_frame(v6);
    check_frame("post_rst", v6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
